// File: rtl/bram_req_adapter.sv
// -----------------------------------------------------------------------------
// bram_req_adapter
//
// Request/response front end for a single-port block RAM (port A) with the
// output register enabled, giving a two-cycle read latency. A valid/ready
// request stream from a bus master is turned into the RAM's raw strobes.
// Reads are tracked through the RAM pipeline, and their data lands in a small
// response FIFO so the master can stall responses without losing anything.
//
// Handshake semantics (both channels): a transfer happens on a rising clka
// edge where valid & ready are both 1. Valid may rise without waiting for
// ready; rsp_valid/rsp_rdata hold stable until taken.
//
// Ports
//   clka, rsta                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr, req_wdata request payload (1 = write)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data, in request order
//   mem_addra, mem_dia          address / write data to the RAM
//   mem_cea, mem_wea, mem_ocea  RAM clock enable, write enable, output reg enable
//   mem_rsta                    RAM output register reset
//   mem_doa                     RAM read data
// -----------------------------------------------------------------------------
module bram_req_adapter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addra,
   output logic [DATA_WIDTH-1:0] mem_dia,
   output logic                  mem_cea,
   output logic                  mem_wea,
   output logic                  mem_ocea,
   output logic                  mem_rsta,
   input  logic [DATA_WIDTH-1:0] mem_doa
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int IW = CW + 1;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(RSP_DEPTH);
   localparam logic [IW-1:0] DEPTH_I   = IW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);

   logic                  r_rd_p1;
   logic                  r_rd_p2;
   logic [CW-1:0]         r_count;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

   logic          w_acc;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [IW-1:0] w_inflight;

   // Every accepted read owns a FIFO slot from issue until it is popped, so
   // counting the reads still in the RAM pipeline alongside the stored ones
   // guarantees a slot exists when the data arrives. Built only from
   // registered state: a pop this cycle frees its credit next cycle.
   assign w_inflight = IW'(r_count) + IW'(r_rd_p1) + IW'(r_rd_p2);
   assign req_ready  = ~rsta & (w_inflight < DEPTH_I);
   assign w_acc      = req_valid & req_ready;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_C);
   assign w_push  = r_rd_p2;
   assign w_pop   = ~w_empty & rsp_ready;

   assign mem_addra = req_addr;
   assign mem_dia   = req_wdata;
   assign mem_cea   = w_acc;
   assign mem_wea   = w_acc & req_we;
   // Output register loads only for real reads, so mem_doa is meaningful
   // exactly when r_rd_p2 is set.
   assign mem_ocea  = r_rd_p1;
   assign mem_rsta  = rsta;

   assign rsp_valid = ~w_empty;
   assign rsp_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clka) begin
      if (rsta) begin
         r_rd_p1  <= 1'b0;
         r_rd_p2  <= 1'b0;
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_rd_p1 <= w_acc & ~req_we;
         r_rd_p2 <= r_rd_p1;
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is deliberately not reset; the pointers and count define validity.
   always_ff @(posedge clka) begin
      if (!rsta && w_push) begin
         r_mem[r_wr_ptr] <= mem_doa;
      end
   end

   // The credit rule makes a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clka) disable iff (rsta) !(w_push && w_full));

endmodule

// File: tb/tb_bram_req_adapter.sv
module tb_bram_req_adapter;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int RSP_DEPTH = 4;

   logic          clka = 1'b0;
   logic          rsta = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] mem_addra;
   logic [DW-1:0] mem_dia;
   logic          mem_cea;
   logic          mem_wea;
   logic          mem_ocea;
   logic          mem_rsta;
   logic [DW-1:0] mem_doa;

   // ---------------- clock ----------------
   always #5 clka = ~clka;

   bram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clka(clka), .rsta(rsta),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_addra(mem_addra), .mem_dia(mem_dia), .mem_cea(mem_cea),
      .mem_wea(mem_wea), .mem_ocea(mem_ocea), .mem_rsta(mem_rsta),
      .mem_doa(mem_doa)
   );

   // ---------------- RAM macro model (2-cycle read, output register) ----------------
   logic [DW-1:0] ram [2048];
   logic [DW-1:0] ram_lat;
   logic [DW-1:0] ram_doa = '0;
   assign mem_doa = ram_doa;

   always @(posedge clka) begin
      if (mem_cea) begin
         if (mem_wea) ram[mem_addra] <= mem_dia;
         else         ram_lat <= ram[mem_addra];
      end
      if (mem_rsta)      ram_doa <= '0;
      else if (mem_ocea) ram_doa <= ram_lat;
   end

   // ---------------- checker ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   // A read accepted in cycle N is due on rsp_valid from cycle N+3 onward and
   // holds its slot until popped; responses leave in acceptance order.
   logic [DW-1:0] shadow [2048];
   logic [DW-1:0] exp_q[$];
   int            stamp_q[$];
   int            cyc = 0;
   int            n_acc = 0;
   logic          last_rd = 1'b0;

   initial begin
      logic exp_ready, exp_rv, acc;
      forever begin
         @(negedge clka);
         exp_ready = !rsta && (exp_q.size() < RSP_DEPTH);
         exp_rv    = (exp_q.size() != 0) && (stamp_q[0] + 3 <= cyc);
         acc       = req_valid && exp_ready;
         check_eq("req_ready", req_ready, exp_ready);
         check_eq("mem_rsta", mem_rsta, rsta);
         check_eq("mem_ocea", mem_ocea, last_rd);
         check_eq("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv) check_eq("rsp_rdata", rsp_rdata, exp_q[0]);
         check_eq("mem_cea", mem_cea, acc);
         check_eq("mem_wea", mem_wea, acc && req_we);
         if (acc) begin
            check_eq("mem_addra", mem_addra, req_addr);
            check_eq("mem_dia", mem_dia, req_wdata);
         end
         last_rd = acc && !req_we;
         if (rsta) begin
            exp_q.delete();
            stamp_q.delete();
         end else begin
            if (exp_rv && rsp_ready) begin
               void'(exp_q.pop_front());
               void'(stamp_q.pop_front());
            end
            if (acc) begin
               n_acc++;
               if (req_we) shadow[req_addr] = req_wdata;
               else begin
                  exp_q.push_back(shadow[req_addr]);
                  stamp_q.push_back(cyc);
               end
            end
         end
         cyc++;
      end
   end

   // ---------------- response-side driver ----------------
   int rsp_mode = 1;  // 0 = stall, 1 = always ready, 2 = random
   initial begin
      forever begin
         @(posedge clka);
         #1;
         case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- request-side driver tasks ----------------
   task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(negedge clka);
      while (!req_ready && n < 200) begin
         @(negedge clka);
         n++;
      end
      if (!req_ready) check_eq("req_timeout", req_ready, 1);
      @(posedge clka);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clka);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      req_valid = 1'b0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clka);
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
      idle(2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      rsp_mode = 1;
      rsta = 1'b1;
      repeat (3) @(posedge clka);
      #1;
      rsta = 1'b0;

      // Single write then read
      do_req(1'b1, 11'h005, 32'hDEADBEEF);
      do_req(1'b0, 11'h005, '0);
      drain();

      // Fill 0..7, then back-to-back reads
      for (int k = 0; k < 8; k++) do_req(1'b1, AW'(k), 32'h01010101 * k);
      for (int k = 0; k < 8; k++) do_req(1'b0, AW'(k), '0);
      drain();

      // Response stall: only four reads fit
      rsp_mode = 0;
      idle(1);
      base = n_acc;
      for (int k = 0; k < 4; k++) do_req(1'b0, AW'(k), '0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 11'd4;
      repeat (8) @(posedge clka);
      #1;
      check_eq("stall_accepts", n_acc - base, 4);
      rsp_mode = 1;
      do_req(1'b0, 11'd4, '0);
      do_req(1'b0, 11'd5, '0);
      drain();

      // Alternating write/read to one address
      for (int i = 0; i < 8; i++) begin
         do_req(1'b1, 11'h100, 32'h11111111 * (i + 1));
         do_req(1'b0, 11'h100, '0);
      end
      drain();

      // Reset while reads are in flight
      do_req(1'b0, 11'd1, '0);
      do_req(1'b0, 11'd2, '0);
      do_req(1'b0, 11'd3, '0);
      req_valid = 1'b0;
      @(posedge clka);
      #1;
      rsta = 1'b1;
      @(posedge clka);
      #1;
      rsta = 1'b0;
      idle(4);
      do_req(1'b0, 11'd3, '0);
      drain();

      // Random traffic against the model
      for (int k = 0; k < 16; k++) do_req(1'b1, AW'(k), $urandom);
      rsp_mode = 2;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      end
      rsp_mode = 1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
